// File: rtl/ctr_decryption_pkg.sv
// Shared types, widths and AES round helpers for the CTR-mode decryption block.
// The S-box is stored as one packed table so every lookup is a plain index.
package ctr_decryption_pkg;

  localparam int BLOCK_W        = 128;
  localparam int KEY_W          = 256;
  localparam int MAX_BITS_DEF   = 2000;
  localparam int MAX_BLOCKS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WAIT_IN,
    OUT,
    FIN
  } state_t;

  // AES forward S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = SBOX[s[8*i +: 8]];
    end
    return r;
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; the state is column-major.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      a0 = s[127-32*col -: 8];
      a1 = s[119-32*col -: 8];
      a2 = s[111-32*col -: 8];
      a3 = s[103-32*col -: 8];
      r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/ctr_decryption_aes256_core.sv
// Iterative AES-256 forward cipher: one round per clock, round keys expanded on the fly.
// dout holds the ciphertext from the cycle done pulses until the next start.
module aes256_core
  import ctr_decryption_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout,
  output logic               done
);

  localparam logic [3:0] LAST_ROUND = 4'd14;

  logic [BLOCK_W-1:0] st;
  logic [KEY_W-1:0]   kreg;
  logic [3:0]         rnd;
  logic [7:0]         rcon;
  logic               running;

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] round_out;
  logic [31:0]        t;
  logic [31:0]        n0, n1, n2, n3;

  // kreg always holds the current round key in its low half.
  always_comb begin
    shifted   = shift_rows(sub_bytes(st));
    round_out = ((rnd == LAST_ROUND) ? shifted : mix_columns(shifted)) ^ kreg[127:0];
  end

  // Odd rounds produce a round key starting at a multiple of 8 words (RotWord + Rcon).
  always_comb begin
    if (rnd[0]) begin
      t = sub_word({kreg[23:0], kreg[31:24]}) ^ {rcon, 24'h000000};
    end else begin
      t = sub_word(kreg[31:0]);
    end
    n0 = kreg[255:224] ^ t;
    n1 = kreg[223:192] ^ n0;
    n2 = kreg[191:160] ^ n1;
    n3 = kreg[159:128] ^ n2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= '0;
      kreg    <= '0;
      rnd     <= '0;
      rcon    <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        st      <= din ^ key[255:128];
        kreg    <= key;
        rnd     <= 4'd1;
        rcon    <= 8'h01;
        running <= 1'b1;
      end else if (running) begin
        st   <= round_out;
        kreg <= {kreg[127:0], n0, n1, n2, n3};
        if (rnd[0]) begin
          rcon <= xtime(rcon);
        end
        if (rnd == LAST_ROUND) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

  assign dout = st;

endmodule

// File: rtl/ctr_decryption.sv
// CTR-mode AES-256 decryption of a message of up to MAX_BITS bits, one 128-bit block
// at a time; keystream generation, input accept and output hand-off are serialised.
module ctr_decryption
  import ctr_decryption_pkg::*;
#(
  parameter int MAX_BITS   = MAX_BITS_DEF,
  parameter int MAX_BLOCKS = MAX_BLOCKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] iv,
  input  logic [10:0]        length,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_BITS);
  localparam logic [4:0]  MAX_BLK = 5'(MAX_BLOCKS);

  state_t             state, state_n;
  logic [KEY_W-1:0]   key_q;
  logic [BLOCK_W-1:0] ctr_q;
  logic [BLOCK_W-1:0] ks_q;
  logic [BLOCK_W-1:0] out_data_q;
  logic [6:0]         rem_q;
  logic [4:0]         nblk_q;
  logic [4:0]         blk_q;
  logic               core_pending;

  logic               core_start;
  logic               core_done;
  logic [BLOCK_W-1:0] core_dout;

  logic [10:0]        len_clamp;
  logic [11:0]        len_round;
  logic [4:0]         nblk_raw;
  logic [4:0]         nblk_calc;
  logic               is_last;
  logic [BLOCK_W-1:0] tail_mask;

  always_comb begin
    len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
    len_round = {1'b0, len_clamp} + 12'd127;
    nblk_raw  = 5'(len_round >> 7);
    nblk_calc = (nblk_raw > MAX_BLK) ? MAX_BLK : nblk_raw;
  end

  // Only the final block of a message with a partial tail gets its low bits cleared.
  always_comb begin
    is_last   = (blk_q == nblk_q - 5'd1);
    tail_mask = (is_last && rem_q != 7'd0) ? ~({BLOCK_W{1'b1}} >> rem_q) : {BLOCK_W{1'b1}};
  end

  aes256_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .key   (key_q),
    .din   (ctr_q),
    .dout  (core_dout),
    .done  (core_done)
  );

  always_comb begin
    state_n    = state;
    core_start = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (nblk_calc != 5'd0) ? GEN : FIN;
        end
      end
      GEN: begin
        core_start = !core_pending;
        if (core_done) begin
          state_n = WAIT_IN;
        end
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = (blk_q + 5'd1 < nblk_q) ? GEN : FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      key_q        <= '0;
      ctr_q        <= '0;
      ks_q         <= '0;
      out_data_q   <= '0;
      rem_q        <= '0;
      nblk_q       <= '0;
      blk_q        <= '0;
      core_pending <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            key_q  <= key;
            ctr_q  <= iv;
            rem_q  <= len_clamp[6:0];
            nblk_q <= nblk_calc;
            blk_q  <= '0;
          end
        end
        GEN: begin
          if (core_start) begin
            core_pending <= 1'b1;
          end
          // The counter advances as soon as its keystream is captured.
          if (core_done) begin
            ks_q         <= core_dout;
            ctr_q        <= ctr_q + 128'd1;
            core_pending <= 1'b0;
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            out_data_q <= (in_data ^ ks_q) & tail_mask;
          end
        end
        OUT: begin
          if (out_ready) begin
            blk_q <= blk_q + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_last = out_valid && is_last;
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

endmodule

// File: tb/tb_ctr_decryption.sv
// Directed bench for ctr_decryption using NIST SP800-38A CTR-AES256 and FIPS-197 vectors.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ctr_decryption;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic [127:0] iv;
  logic [10:0]  length;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  int compare_count  = 0;
  int mismatch_count = 0;

  localparam logic [255:0] NIST_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] NIST_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] nist_ct [4];
  logic [127:0] nist_pt [4];

  ctr_decryption dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .iv        (iv),
    .length    (length),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"},  128'(in_ready),  128'h0);
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'h0);
    checkOutput({tag, "_out_last"},  128'(out_last),  128'h0);
    checkOutput({tag, "_busy"},      128'(busy),      128'h0);
    checkOutput({tag, "_done"},      128'(done),      128'h0);
    checkOutput({tag, "_out_data"},  out_data,        128'h0);
  endtask

  task automatic applyStimulus(input logic [255:0] k, input logic [127:0] v, input logic [10:0] len);
    key    = k;
    iv     = v;
    length = len;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic sendBlock(input string tag, input logic [127:0] ct);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_in_ready"}, 128'(in_ready), 128'h1);
    if (in_ready) begin
      in_valid = 1'b1;
      in_data  = ct;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic takeBlock(input string tag, output logic [127:0] data, output logic last);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'h1);
    data = out_data;
    last = out_last;
    if (out_valid) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic endMessage(input string tag);
    checkOutput({tag, "_done"}, 128'(done), 128'h1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_clear"}, 128'(done), 128'h0);
    checkOutput({tag, "_busy_clear"}, 128'(busy), 128'h0);
  endtask

  // Full-length NIST stream: first four blocks are known, the rest use all-ones ciphertext.
  task automatic runStream(input string tag, input logic [10:0] len, input int exp_blocks, input int zero_bits);
    logic [127:0] d, ct, low_mask;
    logic         l;
    int           early = 0;
    low_mask = (128'h1 << zero_bits) - 128'h1;
    applyStimulus(NIST_KEY, NIST_IV, len);
    for (int b = 0; b < exp_blocks; b++) begin
      if (b < 4) ct = nist_ct[b];
      else       ct = '1;
      sendBlock($sformatf("%s_b%0d", tag, b), ct);
      takeBlock($sformatf("%s_b%0d", tag, b), d, l);
      if (b < 4) checkOutput($sformatf("%s_pt%0d", tag, b), d, nist_pt[b]);
      if (b < exp_blocks - 1) begin
        early += int'(l);
      end else begin
        checkOutput({tag, "_last"}, 128'(l), 128'h1);
        checkOutput({tag, "_tail_zero"}, d & low_mask, 128'h0);
      end
    end
    checkOutput({tag, "_early_last"}, 128'(early), 128'h0);
    endMessage(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] d;
    logic         l;

    nist_ct[0] = 128'h601ec313775789a5b7a7f504bbf3d228;
    nist_ct[1] = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
    nist_ct[2] = 128'h2b0930daa23de94ce87017ba2d84988d;
    nist_ct[3] = 128'hdfc9c58db67aada613c2dd08457941a6;
    nist_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    nist_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    nist_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    nist_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;

    rst = 1'b1; start = 1'b0; key = '0; iv = '0; length = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;

    // NIST L=256 with an output stall and a start pulse while busy
    applyStimulus(NIST_KEY, NIST_IV, 11'd256);
    checkOutput("nist_busy", 128'(busy), 128'h1);
    sendBlock("nist_b0", nist_ct[0]);
    key = '0; length = 11'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_data%0d", i), out_data, nist_pt[0]);
      checkOutput($sformatf("stall_valid%0d", i), 128'(out_valid), 128'h1);
      @(posedge clk);
      #1;
    end
    checkOutput("stall_busy", 128'(busy), 128'h1);
    takeBlock("nist_b0", d, l);
    checkOutput("nist_pt0", d, nist_pt[0]);
    checkOutput("nist_last0", 128'(l), 128'h0);
    sendBlock("nist_b1", nist_ct[1]);
    takeBlock("nist_b1", d, l);
    checkOutput("nist_pt1", d, nist_pt[1]);
    checkOutput("nist_last1", 128'(l), 128'h1);
    endMessage("nist");

    // L=200: second block keeps only its top 72 bits
    applyStimulus(NIST_KEY, NIST_IV, 11'd200);
    sendBlock("l200_b0", nist_ct[0]);
    takeBlock("l200_b0", d, l);
    checkOutput("l200_pt0", d, nist_pt[0]);
    checkOutput("l200_last0", 128'(l), 128'h0);
    sendBlock("l200_b1", nist_ct[1]);
    takeBlock("l200_b1", d, l);
    checkOutput("l200_pt1", d, 128'hae2d8a571e03ac9c9e00000000000000);
    checkOutput("l200_last1", 128'(l), 128'h1);
    endMessage("l200");

    // FIPS-197 C.3 single block: zero ciphertext exposes the keystream
    applyStimulus(FIPS_KEY, 128'h00112233445566778899aabbccddeeff, 11'd128);
    sendBlock("fips_b0", 128'h0);
    takeBlock("fips_b0", d, l);
    checkOutput("fips_pt0", d, 128'h8ea2b7ca516745bfeafc49904b496089);
    checkOutput("fips_last0", 128'(l), 128'h1);
    endMessage("fips");

    // Counter wrap: all-ones IV makes block 1 use counter 0; AES-256(0,0) is known
    applyStimulus(256'h0, '1, 11'd256);
    sendBlock("wrap_b0", 128'h0);
    takeBlock("wrap_b0", d, l);
    checkOutput("wrap_last0", 128'(l), 128'h0);
    sendBlock("wrap_b1", 128'h0);
    takeBlock("wrap_b1", d, l);
    checkOutput("wrap_pt1", d, 128'hdc95c078a2408989ad48a21492842087);
    checkOutput("wrap_last1", 128'(l), 128'h1);
    endMessage("wrap");

    // Empty message goes straight to FIN
    applyStimulus(NIST_KEY, NIST_IV, 11'd0);
    checkOutput("len0_in_ready", 128'(in_ready), 128'h0);
    checkOutput("len0_out_valid", 128'(out_valid), 128'h0);
    endMessage("len0");

    runStream("l2000", 11'd2000, 16, 48);
    runStream("clamp", 11'd2047, 16, 48);

    // Reset while block 3 of 16 is being presented
    applyStimulus(NIST_KEY, NIST_IV, 11'd2000);
    for (int b = 0; b < 3; b++) begin
      sendBlock($sformatf("abort_b%0d", b), nist_ct[b]);
      takeBlock($sformatf("abort_b%0d", b), d, l);
    end
    sendBlock("abort_b3", nist_ct[3]);
    checkOutput("abort_pre_valid", 128'(out_valid), 128'h1);
    rst = 1'b1;
    #1;
    checkIdle("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(NIST_KEY, NIST_IV, 11'd256);
    sendBlock("fresh_b0", nist_ct[0]);
    takeBlock("fresh_b0", d, l);
    checkOutput("fresh_pt0", d, nist_pt[0]);
    sendBlock("fresh_b1", nist_ct[1]);
    takeBlock("fresh_b1", d, l);
    checkOutput("fresh_pt1", d, nist_pt[1]);
    checkOutput("fresh_last1", 128'(l), 128'h1);
    endMessage("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
